// File: rtl/frequency_meter_pkg.sv
// Shared definitions for the frequency meter.
//   fm_state_t : meter state encoding (idle / waiting for first edge / tracking)
//   FM_SYNC_STAGES : number of synchronizer flops ahead of the edge detector
package frequency_meter_pkg;

  typedef enum logic [1:0] {
    FM_IDLE       = 2'd0,
    FM_WAIT_FIRST = 2'd1,
    FM_TRACK      = 2'd2
  } fm_state_t;

  localparam int FM_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous signal into the clock_in domain and flags its
// rising edges.
//   clock_in : sampling clock (rising edge)
//   nreset   : asynchronous active-low reset, clears every flop
//   din      : asynchronous input
//   rise     : high for one clock_in cycle per synchronized 0->1 of din
module sync_edge_detect (
  input  logic clock_in,
  input  logic nreset,
  input  logic din,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic dly;

  always_ff @(posedge clock_in or negedge nreset) begin
    if (!nreset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dly   <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  // dly lags sync2 by one cycle, so this is a single-cycle pulse per edge.
  assign rise = sync2 & ~dly;

endmodule

// File: rtl/frequency_meter.sv
// Counts rising edges of clk_meas over a fixed gate window and measures the
// spacing between successive rising edges, both in clock_in cycles.
//   clock_in     : single clock, all state on its rising edge
//   nreset       : asynchronous active-low reset
//   clk_meas     : asynchronous signal under measurement
//   enable       : high runs the meter, low idles it
//   edge_count   : rising edges in the last completed window (saturating)
//   overflow     : the last window's count reached its maximum
//   result_valid : one-cycle strobe, edge_count/overflow carry new values
//                  in the same cycle; no back-pressure, a strobe is never held
//   period       : clock_in cycles between the last two rising edges
//   period_valid : period holds a real (unsaturated, non-stalled) measurement
//   no_signal    : no rising edge for 2^PERIOD_W-1 cycles
//   state_dbg    : current meter state (fm_state_t encoding)
module frequency_meter
  import frequency_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 1000,
  parameter int COUNT_W     = 16,
  parameter int PERIOD_W    = 16
) (
  input  logic                clock_in,
  input  logic                nreset,
  input  logic                clk_meas,
  input  logic                enable,
  output logic [COUNT_W-1:0]  edge_count,
  output logic                overflow,
  output logic                result_valid,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                no_signal,
  output logic [1:0]          state_dbg
);

  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0]   GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0]  COUNT_MAX  = '1;
  localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

  fm_state_t           state;
  logic [GATE_W-1:0]   gate_cnt;
  logic [COUNT_W-1:0]  edge_acc;
  logic                ovf_acc;
  logic [PERIOD_W-1:0] per_cnt;
  logic                rise;

  logic                gate_last;
  logic [COUNT_W-1:0]  edge_next;
  logic                edge_sat;

  sync_edge_detect u_sync (
    .clock_in (clock_in),
    .nreset   (nreset),
    .din      (clk_meas),
    .rise     (rise)
  );

  // edge_next already includes a rise landing in the closing cycle, so that
  // edge is credited to the window that is ending.
  always_comb begin
    gate_last = (gate_cnt == GATE_LAST);
    edge_next = edge_acc;
    if (rise && (edge_acc != COUNT_MAX)) begin
      edge_next = edge_acc + 1'b1;
    end
    edge_sat = (edge_next == COUNT_MAX);
  end

  always_ff @(posedge clock_in or negedge nreset) begin
    if (!nreset) begin
      state        <= FM_IDLE;
      gate_cnt     <= '0;
      edge_acc     <= '0;
      ovf_acc      <= 1'b0;
      per_cnt      <= '0;
      edge_count   <= '0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      no_signal    <= 1'b0;
    end else if (!enable) begin
      // Dropping enable discards any partial window; published results hold.
      state        <= FM_IDLE;
      gate_cnt     <= '0;
      edge_acc     <= '0;
      ovf_acc      <= 1'b0;
      per_cnt      <= '0;
      result_valid <= 1'b0;
      period_valid <= 1'b0;
      no_signal    <= 1'b0;
    end else begin
      case (state)
        FM_IDLE: begin
          // Counters are already clear; the first window starts next cycle.
          state        <= FM_WAIT_FIRST;
          result_valid <= 1'b0;
        end
        default: begin
          result_valid <= gate_last;
          gate_cnt     <= gate_last ? '0 : gate_cnt + 1'b1;

          if (gate_last) begin
            edge_count <= edge_next;
            overflow   <= ovf_acc | edge_sat;
            edge_acc   <= '0;
            ovf_acc    <= 1'b0;
          end else begin
            edge_acc <= edge_next;
            ovf_acc  <= ovf_acc | edge_sat;
          end

          if (state == FM_WAIT_FIRST) begin
            if (rise) begin
              per_cnt <= PERIOD_W'(1);
              state   <= FM_TRACK;
            end
          end else if (rise) begin
            // A saturated per_cnt is reported but never marked valid.
            period       <= per_cnt;
            period_valid <= !no_signal && (per_cnt != PERIOD_MAX);
            per_cnt      <= PERIOD_W'(1);
            no_signal    <= 1'b0;
          end else if (per_cnt == PERIOD_MAX) begin
            no_signal <= 1'b1;
          end else begin
            per_cnt <= per_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule
